// File: rtl/dma_axil_pkg.sv
// Shared types and constants for the DMA AXI-Lite register-port arbiter.
// Used by the two-port round-robin and the transaction sequencer.
package dma_axil_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RRESP
    } state_t;

endpackage

// File: rtl/dma_axil_arbiter_rr.sv
// Two-requester round-robin: the port that did not win last time wins ties.
// The pointer moves only when the caller commits a grant.
module rr_arbiter_2
    import dma_axil_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 grant_en,
    output logic [NUM_PORTS-1:0] gnt
);

    logic last;

    always_comb begin
        gnt = '0;
        if (req[~last])
            gnt[~last] = 1'b1;
        else if (req[last])
            gnt[last] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (grant_en && |gnt)
            last <= gnt[1];
    end

endmodule

// File: rtl/dma_axil_arbiter.sv
// Shares the DMA AXI-Lite register slave between two masters, one whole
// transaction at a time, with every output driven from a register.
module dma_axil_arbiter
    import dma_axil_pkg::*;
#(
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [C_ADDR_WIDTH-1:0]   S0_AXI_AWADDR,
    input  logic                      S0_AXI_AWVALID,
    output logic                      S0_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S0_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S0_AXI_WSTRB,
    input  logic                      S0_AXI_WVALID,
    output logic                      S0_AXI_WREADY,
    output logic [1:0]                S0_AXI_BRESP,
    output logic                      S0_AXI_BVALID,
    input  logic                      S0_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S0_AXI_ARADDR,
    input  logic                      S0_AXI_ARVALID,
    output logic                      S0_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]   S0_AXI_RDATA,
    output logic [1:0]                S0_AXI_RRESP,
    output logic                      S0_AXI_RVALID,
    input  logic                      S0_AXI_RREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S1_AXI_AWADDR,
    input  logic                      S1_AXI_AWVALID,
    output logic                      S1_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]   S1_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] S1_AXI_WSTRB,
    input  logic                      S1_AXI_WVALID,
    output logic                      S1_AXI_WREADY,
    output logic [1:0]                S1_AXI_BRESP,
    output logic                      S1_AXI_BVALID,
    input  logic                      S1_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]   S1_AXI_ARADDR,
    input  logic                      S1_AXI_ARVALID,
    output logic                      S1_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]   S1_AXI_RDATA,
    output logic [1:0]                S1_AXI_RRESP,
    output logic                      S1_AXI_RVALID,
    input  logic                      S1_AXI_RREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY,
    output logic [1:0]                GRANT
);

    localparam int SW = C_DATA_WIDTH / 8;

    state_t                  state;
    logic [NUM_PORTS-1:0]    wreq, rreq, win, grant_q;
    logic [NUM_PORTS-1:0]    awready_q, wready_q, arready_q;
    logic [NUM_PORTS-1:0]    bvalid_q, rvalid_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [SW-1:0]           wstrb_q;
    logic [1:0]              bresp_q, rresp_q;
    logic                    m_awvalid_q, m_wvalid_q, m_arvalid_q;
    logic                    m_bready_q, m_rready_q;
    logic                    aw_done, w_done;
    logic                    aw_fire, w_fire, own_bready, own_rready;
    logic                    grant_en;

    assign wreq = {S1_AXI_AWVALID & S1_AXI_WVALID,
                   S0_AXI_AWVALID & S0_AXI_WVALID};
    assign rreq = {S1_AXI_ARVALID, S0_AXI_ARVALID};
    assign grant_en = (state == IDLE);

    rr_arbiter_2 u_rr (
        .clk      (ACLK),
        .rst      (ARESET),
        .req      (wreq | rreq),
        .grant_en (grant_en),
        .gnt      (win)
    );

    assign aw_fire    = m_awvalid_q & M_AXI_AWREADY;
    assign w_fire     = m_wvalid_q & M_AXI_WREADY;
    assign own_bready = grant_q[1] ? S1_AXI_BREADY : S0_AXI_BREADY;
    assign own_rready = grant_q[1] ? S1_AXI_RREADY : S0_AXI_RREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= IDLE;
            grant_q     <= '0;
            awready_q   <= '0;
            wready_q    <= '0;
            arready_q   <= '0;
            bvalid_q    <= '0;
            rvalid_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_arvalid_q <= 1'b0;
            m_bready_q  <= 1'b0;
            m_rready_q  <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            awready_q <= '0;
            wready_q  <= '0;
            arready_q <= '0;
            unique case (state)
                IDLE: begin
                    if (|win) begin
                        grant_q <= win;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (|(wreq & win)) begin
                            awready_q <= win;
                            wready_q  <= win;
                            addr_q  <= win[1] ? S1_AXI_AWADDR : S0_AXI_AWADDR;
                            wdata_q <= win[1] ? S1_AXI_WDATA : S0_AXI_WDATA;
                            wstrb_q <= win[1] ? S1_AXI_WSTRB : S0_AXI_WSTRB;
                            state   <= WADDR;
                        end else begin
                            arready_q <= win;
                            addr_q <= win[1] ? S1_AXI_ARADDR : S0_AXI_ARADDR;
                            state  <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    // First cycle: the ready pulse to the owner is still up.
                    if (|awready_q) begin
                        m_awvalid_q <= 1'b1;
                        m_wvalid_q  <= 1'b1;
                    end else begin
                        if (aw_fire) m_awvalid_q <= 1'b0;
                        if (w_fire)  m_wvalid_q  <= 1'b0;
                        aw_done <= aw_done | aw_fire;
                        w_done  <= w_done | w_fire;
                        if ((aw_done | aw_fire) && (w_done | w_fire)) begin
                            m_bready_q <= 1'b1;
                            state      <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (m_bready_q && M_AXI_BVALID) begin
                        m_bready_q <= 1'b0;
                        bresp_q    <= M_AXI_BRESP;
                        bvalid_q   <= grant_q;
                    end else if (|bvalid_q && own_bready) begin
                        bvalid_q <= '0;
                        bresp_q  <= RESP_OKAY;
                        grant_q  <= '0;
                        state    <= IDLE;
                    end
                end
                RADDR: begin
                    if (|arready_q) begin
                        m_arvalid_q <= 1'b1;
                    end else if (m_arvalid_q && M_AXI_ARREADY) begin
                        m_arvalid_q <= 1'b0;
                        m_rready_q  <= 1'b1;
                        state       <= RRESP;
                    end
                end
                RRESP: begin
                    if (m_rready_q && M_AXI_RVALID) begin
                        m_rready_q <= 1'b0;
                        rdata_q    <= M_AXI_RDATA;
                        rresp_q    <= M_AXI_RRESP;
                        rvalid_q   <= grant_q;
                    end else if (|rvalid_q && own_rready) begin
                        rvalid_q <= '0;
                        rdata_q  <= '0;
                        rresp_q  <= RESP_OKAY;
                        grant_q  <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign GRANT = grant_q;

    assign S0_AXI_AWREADY = awready_q[0];
    assign S0_AXI_WREADY  = wready_q[0];
    assign S0_AXI_ARREADY = arready_q[0];
    assign S0_AXI_BVALID  = bvalid_q[0];
    assign S0_AXI_RVALID  = rvalid_q[0];
    assign S0_AXI_BRESP   = grant_q[0] ? bresp_q : RESP_OKAY;
    assign S0_AXI_RRESP   = grant_q[0] ? rresp_q : RESP_OKAY;
    assign S0_AXI_RDATA   = grant_q[0] ? rdata_q : '0;

    assign S1_AXI_AWREADY = awready_q[1];
    assign S1_AXI_WREADY  = wready_q[1];
    assign S1_AXI_ARREADY = arready_q[1];
    assign S1_AXI_BVALID  = bvalid_q[1];
    assign S1_AXI_RVALID  = rvalid_q[1];
    assign S1_AXI_BRESP   = grant_q[1] ? bresp_q : RESP_OKAY;
    assign S1_AXI_RRESP   = grant_q[1] ? rresp_q : RESP_OKAY;
    assign S1_AXI_RDATA   = grant_q[1] ? rdata_q : '0;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWVALID = m_awvalid_q;
    assign M_AXI_WVALID  = m_wvalid_q;
    assign M_AXI_ARVALID = m_arvalid_q;
    assign M_AXI_BREADY  = m_bready_q;
    assign M_AXI_RREADY  = m_rready_q;

endmodule

// File: tb/tb_dma_axil_arbiter.sv
// Directed bench for dma_axil_arbiter: scripted masters and slave,
// hand-computed expectations checked with immediate assertions.
module tb_dma_axil_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] S0_AXI_AWADDR, S0_AXI_WDATA, S0_AXI_ARADDR, S0_AXI_RDATA;
    logic [3:0]  S0_AXI_WSTRB;
    logic        S0_AXI_AWVALID, S0_AXI_AWREADY, S0_AXI_WVALID, S0_AXI_WREADY;
    logic [1:0]  S0_AXI_BRESP, S0_AXI_RRESP;
    logic        S0_AXI_BVALID, S0_AXI_BREADY, S0_AXI_ARVALID, S0_AXI_ARREADY;
    logic        S0_AXI_RVALID, S0_AXI_RREADY;
    logic [31:0] S1_AXI_AWADDR, S1_AXI_WDATA, S1_AXI_ARADDR, S1_AXI_RDATA;
    logic [3:0]  S1_AXI_WSTRB;
    logic        S1_AXI_AWVALID, S1_AXI_AWREADY, S1_AXI_WVALID, S1_AXI_WREADY;
    logic [1:0]  S1_AXI_BRESP, S1_AXI_RRESP;
    logic        S1_AXI_BVALID, S1_AXI_BREADY, S1_AXI_ARVALID, S1_AXI_ARREADY;
    logic        S1_AXI_RVALID, S1_AXI_RREADY;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  GRANT;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 ACLK = ~ACLK;

    dma_axil_arbiter dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S0_AXI_AWADDR(S0_AXI_AWADDR), .S0_AXI_AWVALID(S0_AXI_AWVALID),
        .S0_AXI_AWREADY(S0_AXI_AWREADY), .S0_AXI_WDATA(S0_AXI_WDATA),
        .S0_AXI_WSTRB(S0_AXI_WSTRB), .S0_AXI_WVALID(S0_AXI_WVALID),
        .S0_AXI_WREADY(S0_AXI_WREADY), .S0_AXI_BRESP(S0_AXI_BRESP),
        .S0_AXI_BVALID(S0_AXI_BVALID), .S0_AXI_BREADY(S0_AXI_BREADY),
        .S0_AXI_ARADDR(S0_AXI_ARADDR), .S0_AXI_ARVALID(S0_AXI_ARVALID),
        .S0_AXI_ARREADY(S0_AXI_ARREADY), .S0_AXI_RDATA(S0_AXI_RDATA),
        .S0_AXI_RRESP(S0_AXI_RRESP), .S0_AXI_RVALID(S0_AXI_RVALID),
        .S0_AXI_RREADY(S0_AXI_RREADY),
        .S1_AXI_AWADDR(S1_AXI_AWADDR), .S1_AXI_AWVALID(S1_AXI_AWVALID),
        .S1_AXI_AWREADY(S1_AXI_AWREADY), .S1_AXI_WDATA(S1_AXI_WDATA),
        .S1_AXI_WSTRB(S1_AXI_WSTRB), .S1_AXI_WVALID(S1_AXI_WVALID),
        .S1_AXI_WREADY(S1_AXI_WREADY), .S1_AXI_BRESP(S1_AXI_BRESP),
        .S1_AXI_BVALID(S1_AXI_BVALID), .S1_AXI_BREADY(S1_AXI_BREADY),
        .S1_AXI_ARADDR(S1_AXI_ARADDR), .S1_AXI_ARVALID(S1_AXI_ARVALID),
        .S1_AXI_ARREADY(S1_AXI_ARREADY), .S1_AXI_RDATA(S1_AXI_RDATA),
        .S1_AXI_RRESP(S1_AXI_RRESP), .S1_AXI_RVALID(S1_AXI_RVALID),
        .S1_AXI_RREADY(S1_AXI_RREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
        .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
        .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
        .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY),
        .GRANT(GRANT)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESET = 1'b1;
        S0_AXI_AWADDR = '0; S0_AXI_AWVALID = 0; S0_AXI_WDATA = '0;
        S0_AXI_WSTRB = '0; S0_AXI_WVALID = 0; S0_AXI_BREADY = 0;
        S0_AXI_ARADDR = '0; S0_AXI_ARVALID = 0; S0_AXI_RREADY = 0;
        S1_AXI_AWADDR = '0; S1_AXI_AWVALID = 0; S1_AXI_WDATA = '0;
        S1_AXI_WSTRB = '0; S1_AXI_WVALID = 0; S1_AXI_BREADY = 0;
        S1_AXI_ARADDR = '0; S1_AXI_ARVALID = 0; S1_AXI_RREADY = 0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BRESP = '0;
        M_AXI_BVALID = 0; M_AXI_ARREADY = 0; M_AXI_RDATA = '0;
        M_AXI_RRESP = '0; M_AXI_RVALID = 0;
        tick(); tick();
        chk("rst_grant", GRANT, 2'b00);
        chk("rst_m_awvalid", M_AXI_AWVALID, 0);
        chk("rst_m_bready", M_AXI_BREADY, 0);
        chk("rst_s0_awready", S0_AXI_AWREADY, 0);
        ARESET = 1'b0;
        tick();

        // Port 0 write, slave ready immediately.
        S0_AXI_AWADDR = 32'h7D40_0010; S0_AXI_WDATA = 32'hDEAD_BEEF;
        S0_AXI_WSTRB = 4'hF; S0_AXI_AWVALID = 1; S0_AXI_WVALID = 1;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        tick();
        chk("w0_grant", GRANT, 2'b01);
        chk("w0_awready", S0_AXI_AWREADY, 1);
        chk("w0_wready", S0_AXI_WREADY, 1);
        chk("w0_m_awvalid_T", M_AXI_AWVALID, 0);
        tick();
        S0_AXI_AWVALID = 0; S0_AXI_WVALID = 0;
        chk("w0_m_awvalid", M_AXI_AWVALID, 1);
        chk("w0_m_wvalid", M_AXI_WVALID, 1);
        chk("w0_awaddr", M_AXI_AWADDR, 32'h7D40_0010);
        chk("w0_wdata", M_AXI_WDATA, 32'hDEAD_BEEF);
        chk("w0_wstrb", M_AXI_WSTRB, 4'hF);
        chk("w0_awready_drop", S0_AXI_AWREADY, 0);
        tick();
        chk("w0_m_awvalid_drop", M_AXI_AWVALID, 0);
        chk("w0_m_bready", M_AXI_BREADY, 1);
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        tick();
        M_AXI_BVALID = 0;
        chk("w0_bvalid", S0_AXI_BVALID, 1);
        chk("w0_bresp", S0_AXI_BRESP, 2'b00);
        chk("w0_s1_bvalid", S1_AXI_BVALID, 0);
        chk("w0_m_bready_off", M_AXI_BREADY, 0);
        S0_AXI_BREADY = 1;
        tick();
        S0_AXI_BREADY = 0;
        chk("w0_bvalid_done", S0_AXI_BVALID, 0);
        chk("w0_grant_idle", GRANT, 2'b00);

        // Both ports read continuously; port 1 goes first (port 0 won last).
        S0_AXI_ARADDR = 32'h0000_0100; S1_AXI_ARADDR = 32'h0000_0200;
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1;
        S0_AXI_RREADY = 1; S1_AXI_RREADY = 1; M_AXI_ARREADY = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rd%0d_grant", i), GRANT,
                (i % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            chk($sformatf("rd%0d_araddr", i), M_AXI_ARADDR,
                (i % 2 == 0) ? 32'h200 : 32'h100);
            tick();
            M_AXI_RVALID = 1; M_AXI_RDATA = 32'hA000_0000 + i;
            tick();
            M_AXI_RVALID = 0;
            if (i % 2 == 0) begin
                chk($sformatf("rd%0d_s1_rvalid", i), S1_AXI_RVALID, 1);
                chk($sformatf("rd%0d_s1_rdata", i), S1_AXI_RDATA,
                    32'hA000_0000 + i);
                chk($sformatf("rd%0d_s0_rvalid", i), S0_AXI_RVALID, 0);
            end else begin
                chk($sformatf("rd%0d_s0_rvalid", i), S0_AXI_RVALID, 1);
                chk($sformatf("rd%0d_s0_rdata", i), S0_AXI_RDATA,
                    32'hA000_0000 + i);
                chk($sformatf("rd%0d_s1_rvalid", i), S1_AXI_RVALID, 0);
            end
            if (i == 7) begin
                S0_AXI_ARVALID = 0; S1_AXI_ARVALID = 0;
            end
            tick();
            chk($sformatf("rd%0d_idle", i), GRANT, 2'b00);
        end

        // Port 1 write and read together, slow slave, SLVERR response.
        S1_AXI_AWADDR = 32'h7D40_0020; S1_AXI_WDATA = 32'h0BAD_F00D;
        S1_AXI_WSTRB = 4'h3; S1_AXI_AWVALID = 1; S1_AXI_WVALID = 1;
        S1_AXI_ARADDR = 32'h0000_0300; S1_AXI_ARVALID = 1;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        tick();
        chk("p1w_grant", GRANT, 2'b10);
        chk("p1w_awready", S1_AXI_AWREADY, 1);
        chk("p1w_arready", S1_AXI_ARREADY, 0);
        tick();
        S1_AXI_AWVALID = 0; S1_AXI_WVALID = 0;
        chk("p1w_m_awvalid", M_AXI_AWVALID, 1);
        chk("p1w_awaddr", M_AXI_AWADDR, 32'h7D40_0020);
        tick(); tick(); tick();
        M_AXI_AWREADY = 1;
        chk("p1w_awvalid_wait", M_AXI_AWVALID, 1);
        tick();
        M_AXI_AWREADY = 0;
        chk("p1w_awvalid_drop", M_AXI_AWVALID, 0);
        chk("p1w_wvalid_hold", M_AXI_WVALID, 1);
        chk("p1w_bready_wait", M_AXI_BREADY, 0);
        tick();
        M_AXI_WREADY = 1;
        tick();
        M_AXI_WREADY = 0;
        chk("p1w_wvalid_drop", M_AXI_WVALID, 0);
        chk("p1w_m_bready", M_AXI_BREADY, 1);
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b10;
        tick();
        M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
        chk("p1w_bvalid", S1_AXI_BVALID, 1);
        chk("p1w_bresp", S1_AXI_BRESP, 2'b10);
        chk("p1w_s0_bvalid", S0_AXI_BVALID, 0);
        S1_AXI_BREADY = 1;
        tick();
        S1_AXI_BREADY = 0;
        chk("p1w_idle", GRANT, 2'b00);
        tick();
        chk("p1r_grant", GRANT, 2'b10);
        chk("p1r_arready", S1_AXI_ARREADY, 1);
        chk("p1r_awready", S1_AXI_AWREADY, 0);
        tick();
        S1_AXI_ARVALID = 0;
        chk("p1r_araddr", M_AXI_ARADDR, 32'h0000_0300);
        tick();
        M_AXI_RVALID = 1; M_AXI_RDATA = 32'h5555_AAAA;
        tick();
        M_AXI_RVALID = 0;
        chk("p1r_rdata", S1_AXI_RDATA, 32'h5555_AAAA);
        tick();

        // Port 0 write with BREADY held low; port 1 read must wait.
        S0_AXI_AWADDR = 32'h7D40_0030; S0_AXI_WDATA = 32'h1234_5678;
        S0_AXI_AWVALID = 1; S0_AXI_WVALID = 1;
        S1_AXI_ARADDR = 32'h0000_0400; S1_AXI_ARVALID = 1;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        tick();
        chk("bp_grant", GRANT, 2'b01);
        chk("bp_s1_arready", S1_AXI_ARREADY, 0);
        tick();
        S0_AXI_AWVALID = 0; S0_AXI_WVALID = 0;
        tick();
        M_AXI_BVALID = 1;
        tick();
        M_AXI_BVALID = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("bp%0d_bvalid", k), S0_AXI_BVALID, 1);
            chk($sformatf("bp%0d_grant", k), GRANT, 2'b01);
            chk($sformatf("bp%0d_arready", k), S1_AXI_ARREADY, 0);
        end
        S0_AXI_BREADY = 1;
        tick();
        S0_AXI_BREADY = 0;
        chk("bp_done", S0_AXI_BVALID, 0);
        chk("bp_idle", GRANT, 2'b00);
        tick();
        chk("bp_next_grant", GRANT, 2'b10);
        chk("bp_next_arready", S1_AXI_ARREADY, 1);
        tick();
        S1_AXI_ARVALID = 0;
        tick();
        M_AXI_RVALID = 1; M_AXI_RDATA = 32'hCAFE_F00D;
        tick();
        M_AXI_RVALID = 0;
        chk("bp_rdata", S1_AXI_RDATA, 32'hCAFE_F00D);
        tick();

        // Reset while the port 0 write waits in WRESP.
        S0_AXI_AWVALID = 1; S0_AXI_WVALID = 1;
        tick();
        chk("rs_grant", GRANT, 2'b01);
        tick();
        S0_AXI_AWVALID = 0; S0_AXI_WVALID = 0;
        tick();
        chk("rs_in_wresp", M_AXI_BREADY, 1);
        ARESET = 1;
        tick();
        chk("rs_grant0", GRANT, 2'b00);
        chk("rs_bready0", M_AXI_BREADY, 0);
        chk("rs_awvalid0", M_AXI_AWVALID, 0);
        chk("rs_bvalid0", S0_AXI_BVALID, 0);
        ARESET = 0;
        S0_AXI_ARVALID = 1; S1_AXI_ARVALID = 1;
        tick();
        chk("rs_contend", GRANT, 2'b01);
        chk("rs_s0_arready", S0_AXI_ARREADY, 1);
        S0_AXI_ARVALID = 0; S1_AXI_ARVALID = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
